// File: rtl/div_result_display.sv
// div_result_display: BCD conversion of divider results onto a 4-digit multiplexed seven-segment display
module div_result_display #(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       res_valid,
  input  logic [7:0] quo,
  input  logic [3:0] rem,
  input  logic       show_rem,
  output logic       busy,
  output logic       bcd_ready,
  output logic [3:0] an,
  output logic [6:0] seg
);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);
  state_t state, nxt;
  logic [7:0] bin;
  logic [11:0] bcd, adj, disp_q;
  logic [7:0] disp_r;
  logic [3:0] r_r, cnt, dig;
  logic [CNT_W-1:0] pre;
  logic [1:0] idx;
  logic blank;
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction
  function automatic logic [6:0] dec(input logic [3:0] d);
    return d == 4'd0 ? 7'b1000000 : d == 4'd1 ? 7'b1111001 :
           d == 4'd2 ? 7'b0100100 : d == 4'd3 ? 7'b0110000 :
           d == 4'd4 ? 7'b0011001 : d == 4'd5 ? 7'b0010010 :
           d == 4'd6 ? 7'b0000010 : d == 4'd7 ? 7'b1111000 :
           d == 4'd8 ? 7'b0000000 : d == 4'd9 ? 7'b0010000 : 7'h7F;
  endfunction
  assign adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
  assign busy = state != IDLE;
  always_comb begin
    nxt = state;
    if (state == IDLE) nxt = res_valid ? CONV : IDLE;
    else if (state == CONV) nxt = (cnt == 4'd1) ? DONE : CONV;
    else nxt = IDLE;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      bin <= '0;
      bcd <= '0;
      r_r <= '0;
      cnt <= '0;
      disp_q <= '0;
      disp_r <= '0;
      bcd_ready <= 1'b0;
    end else begin
      bcd_ready <= state == DONE;
      if (state == IDLE && res_valid) begin
        bin <= quo;
        r_r <= rem;
        bcd <= '0;
        cnt <= 4'd8;
      end else if (state == CONV) begin
        bcd <= {adj[10:0], bin[7]};
        bin <= {bin[6:0], 1'b0};
        cnt <= cnt - 4'd1;
      end else if (state == DONE) begin
        disp_q <= bcd;
        disp_r <= (r_r >= 4'd10) ? {4'd1, r_r - 4'd10} : {4'd0, r_r};
      end
    end
  end
  always_comb begin
    dig = idx == 2'd0 ? (show_rem ? disp_r[3:0] : disp_q[3:0]) :
          idx == 2'd1 ? (show_rem ? disp_r[7:4] : disp_q[7:4]) : disp_q[11:8];
    blank = idx == 2'd3 ||
            (idx == 2'd2 && (show_rem || disp_q[11:8] == 4'd0)) ||
            (idx == 2'd1 && (show_rem ? disp_r[7:4] == 4'd0 : disp_q[11:4] == 8'd0));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
      an <= 4'hF;
      seg <= 7'h7F;
    end else begin
      pre <= (pre == LAST) ? '0 : pre + 1'b1;
      idx <= (pre == LAST) ? idx + 2'd1 : idx;
      an <= blank ? 4'hF : ~(4'b0001 << idx);
      seg <= blank ? 7'h7F : dec(dig);
    end
  end
endmodule
